axis_upsizer: RTL and testbench

//  Parametrised AXI-Stream width up-converter: packs RATIO narrow input beats (DW_IN) into one wide

---
 rtl/axis_pkg.sv | 18 +
 rtl/axis_sync_fifo.sv | 70 +++++++
 rtl/axis_upsizer.sv | 85 ++++++++
 tb/tb_axis_upsizer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-Stream helpers: default widths, a constant-safe clog2 and lane/keep types.
package axis_pkg;

  localparam int AXIS_DW_IN = 8;
  localparam int AXIS_RATIO = 4;
  localparam int AXIS_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef logic [AXIS_DW_IN-1:0] axis_lane_t;
  typedef logic [AXIS_RATIO-1:0] axis_keep_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word lives in an output register, so a push
// into an empty FIFO is visible on dout the very next cycle.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [LW-1:0] lvl
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_lvl;
  logic [W-1:0]  r_dout;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_mem_empty;
  logic w_bypass;
  logic w_mem_wr;
  logic w_mem_rd;

  assign w_empty     = (r_lvl == '0);
  assign w_full      = (r_lvl == LW'(DEPTH));
  assign w_pop       = pop & ~w_empty;
  assign w_push      = push & (~w_full | w_pop);
  // Everything beyond the head word sits in r_mem.
  assign w_mem_empty = (r_lvl <= LW'(1));
  assign w_bypass    = w_push & (w_empty | (w_pop & w_mem_empty));
  assign w_mem_wr    = w_push & ~w_bypass;
  assign w_mem_rd    = w_pop & ~w_mem_empty;

  always_ff @(posedge clk) begin
    if (w_mem_wr) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_lvl  <= '0;
      r_dout <= '0;
    end else begin
      if (w_bypass)      r_dout <= din;
      else if (w_mem_rd) r_dout <= r_mem[r_rd];
      if (w_mem_wr) r_wr <= r_wr + AW'(1);
      if (w_mem_rd) r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_lvl <= r_lvl + LW'(1);
      else if (!w_push && w_pop) r_lvl <= r_lvl - LW'(1);
    end
  end

  assign dout  = r_dout;
  assign valid = ~w_empty;
  assign lvl   = r_lvl;

endmodule

// File: rtl/axis_upsizer.sv
// AXI-Stream width up-converter: packs RATIO narrow beats little-endian into one wide
// word, flushing early on s_tlast, and queues finished words in a show-ahead FIFO.
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int DW_IN   = AXIS_DW_IN,
  parameter int RATIO   = AXIS_RATIO,
  parameter int DEPTH   = AXIS_DEPTH,
  localparam int DW_OUT = DW_IN * RATIO,
  localparam int LVL_W  = clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW_IN-1:0]  s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DW_OUT-1:0] m_tdata,
  output logic [RATIO-1:0]  m_tkeep,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [LVL_W-1:0]  fifo_lvl
);

  localparam int CNT_W = clog2(RATIO);
  localparam int FW    = DW_OUT + RATIO + 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [DW_OUT-1:0] r_pack;
  logic [RATIO-1:0]  r_keep;

  logic              w_accept;
  logic              w_commit;
  logic [RATIO-1:0]  w_lane_hit;
  logic [DW_OUT-1:0] w_word;
  logic [RATIO-1:0]  w_keep;
  logic [FW-1:0]     w_fifo_dout;
  logic [LVL_W-1:0]  w_lvl;

  assign s_tready = (w_lvl != LVL_W'(DEPTH));
  assign w_accept = s_tvalid & s_tready;
  assign w_commit = w_accept & ((r_cnt == CNT_W'(RATIO - 1)) | s_tlast);

  // The word pushed on commit already contains the committing beat.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign w_lane_hit[gi] = w_accept & (r_cnt == CNT_W'(gi));
    assign w_word[gi*DW_IN +: DW_IN] = w_lane_hit[gi] ? s_tdata : r_pack[gi*DW_IN +: DW_IN];
    assign w_keep[gi] = r_keep[gi] | w_lane_hit[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pack <= '0;
      r_keep <= '0;
    end else if (w_commit) begin
      r_cnt  <= '0;
      r_pack <= '0;
      r_keep <= '0;
    end else if (w_accept) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_pack <= w_word;
      r_keep <= w_keep;
    end
  end

  axis_sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_commit),
    .din   ({s_tlast, w_keep, w_word}),
    .pop   (m_tready),
    .dout  (w_fifo_dout),
    .valid (m_tvalid),
    .lvl   (w_lvl)
  );

  assign {m_tlast, m_tkeep, m_tdata} = w_fifo_dout;
  assign fifo_lvl = w_lvl;

endmodule

// File: tb/tb_axis_upsizer.sv
// Bench for axis_upsizer: directed packets plus random traffic against a queue-based model.
module tb_axis_upsizer;
  import axis_pkg::*;

  localparam int DW_IN  = AXIS_DW_IN;
  localparam int RATIO  = AXIS_RATIO;
  localparam int DEPTH  = AXIS_DEPTH;
  localparam int DW_OUT = DW_IN * RATIO;
  localparam int LVL_W  = clog2(DEPTH) + 1;

  typedef struct {
    logic [DW_OUT-1:0] data;
    logic [RATIO-1:0]  keep;
    logic              last;
  } word_t;

  logic              clk;
  logic              reset;
  logic [DW_IN-1:0]  s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic [DW_OUT-1:0] m_tdata;
  logic [RATIO-1:0]  m_tkeep;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [LVL_W-1:0]  fifo_lvl;

  axis_upsizer dut (
    .clk      (clk),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .fifo_lvl (fifo_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;
  bit rnd_done;

  word_t             exp_q[$];
  word_t             out_log[$];
  logic [DW_IN-1:0]  beat_q[$];
  logic [DW_OUT-1:0] last_data = '0;
  word_t             mon_w;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents == words committed by the source but not yet taken.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("fifo_lvl", 64'(fifo_lvl), 64'(exp_q.size()));
      check_eq("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() != 0));
      check_eq("s_tready", 64'(s_tready), 64'(exp_q.size() != DEPTH));
      if (exp_q.size() != 0) begin
        check_eq("m_tdata", 64'(m_tdata), 64'(exp_q[0].data));
        check_eq("m_tkeep", 64'(m_tkeep), 64'(exp_q[0].keep));
        check_eq("m_tlast", 64'(m_tlast), 64'(exp_q[0].last));
      end else begin
        check_eq("hold_data", 64'(m_tdata), 64'(last_data));
      end
      if (reset) begin
        exp_q.delete();
        beat_q.delete();
        last_data = '0;
      end else begin
        if (m_tvalid && m_tready) begin
          mon_w = '{data: m_tdata, keep: m_tkeep, last: m_tlast};
          out_log.push_back(mon_w);
          last_data = m_tdata;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (s_tvalid && s_tready) begin
          beat_q.push_back(s_tdata);
          if (beat_q.size() == RATIO || s_tlast) begin
            mon_w.data = '0;
            for (int i = 0; i < beat_q.size(); i++)
              mon_w.data = mon_w.data | (DW_OUT'(beat_q[i]) << (DW_IN * i));
            mon_w.keep = RATIO'((1 << beat_q.size()) - 1);
            mon_w.last = s_tlast;
            exp_q.push_back(mon_w);
            beat_q.delete();
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [DW_IN-1:0] d, input logic last);
    int  n;
    logic acc;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    check_eq("beat_accept", 64'(acc), 64'(1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_log(input string tag, input int idx, input logic [DW_OUT-1:0] d,
                           input logic [RATIO-1:0] k, input logic l);
    if (out_log.size() > idx) begin
      check_eq({tag, "_data"}, 64'(out_log[idx].data), 64'(d));
      check_eq({tag, "_keep"}, 64'(out_log[idx].keep), 64'(k));
      check_eq({tag, "_last"}, 64'(out_log[idx].last), 64'(l));
    end else begin
      check_eq({tag, "_present"}, 64'(out_log.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int base;
    int n;
    int t0;
    logic [DW_OUT-1:0] held;
    logic [DW_OUT-1:0] w;

    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;

    // 1: reset state
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_s_tready", 64'(s_tready), 64'(1));
    check_eq("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check_eq("rst_fifo_lvl", 64'(fifo_lvl), 64'(0));
    check_eq("rst_m_tdata", 64'(m_tdata), 64'(0));
    check_eq("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    check_eq("rst_m_tlast", 64'(m_tlast), 64'(0));

    // 2: full packet of four beats
    base = out_log.size();
    send_beat(8'h68, 1'b0);
    send_beat(8'h65, 1'b0);
    send_beat(8'h6C, 1'b0);
    check_eq("t2_no_early", 64'(m_tvalid), 64'(0));
    send_beat(8'h6F, 1'b1);
    check_eq("t2_latency", 64'(m_tvalid), 64'(1));
    drain();
    check_log("t2", base, 32'h6F6C6568, 4'hF, 1'b1);

    // 3: partial flush
    base = out_log.size();
    send_beat(8'hAA, 1'b0);
    send_beat(8'hBB, 1'b1);
    drain();
    check_log("t3", base, 32'h0000BBAA, 4'b0011, 1'b1);

    // 4: back-pressure, 20 beats into a 4-word FIFO
    base = out_log.size();
    m_tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_beat(DW_IN'(8'h80 + i), i == 19);
      end
      begin
        n = 0;
        while (fifo_lvl != LVL_W'(DEPTH) && n < 300) begin
          @(posedge clk); #1; n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("t4_full_lvl", 64'(fifo_lvl), 64'(DEPTH));
        check_eq("t4_full_rdy", 64'(s_tready), 64'(0));
        held = m_tdata;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_stable", 64'(m_tdata), 64'(held));
        m_tready = 1'b1;
      end
    join
    drain();
    check_eq("t4_count", 64'(out_log.size() - base), 64'(5));
    for (int wi = 0; wi < 5; wi++) begin
      w = '0;
      for (int b = 0; b < RATIO; b++) w = w | (DW_OUT'(8'h80 + 4 * wi + b) << (DW_IN * b));
      check_log("t4", base + wi, w, 4'hF, wi == 4);
    end

    // 5: sustained streaming
    base = out_log.size();
    t0 = cyc;
    for (int i = 0; i < 64; i++) send_beat(DW_IN'(i), i == 63);
    check_eq("t5_cycles", 64'(cyc - t0), 64'(64));
    drain();
    check_eq("t5_count", 64'(out_log.size() - base), 64'(16));
    for (int wi = 0; wi < 16; wi++) begin
      w = {DW_IN'(4 * wi + 3), DW_IN'(4 * wi + 2), DW_IN'(4 * wi + 1), DW_IN'(4 * wi)};
      check_log("t5", base + wi, w, 4'hF, wi == 15);
    end

    // 6: reset with words queued and a partial packet pending
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(DW_IN'(8'hC0 + i), 1'b0);
    send_beat(8'hE1, 1'b0);
    send_beat(8'hE2, 1'b0);
    check_eq("t6_queued", 64'(fifo_lvl), 64'(2));
    base = out_log.size();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("t6_m_tvalid", 64'(m_tvalid), 64'(0));
    check_eq("t6_fifo_lvl", 64'(fifo_lvl), 64'(0));
    m_tready = 1'b1;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    drain();
    check_eq("t6_count", 64'(out_log.size() - base), 64'(1));
    check_log("t6", base, 32'h44332211, 4'hF, 1'b1);

    // 7: random traffic with random back-pressure and packet lengths
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_beat(DW_IN'($urandom), $urandom_range(0, 5) == 0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_tready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
